// File: rtl/gpio_pkg.sv
// Shared constants for the APB GPIO block: register offsets, interrupt encodings
// and the byte-strobe mask helper.
package gpio_pkg;

   localparam int GPIO_MAX_W = 32;

   localparam logic [31:0] OFF_DIR        = 32'h00;
   localparam logic [31:0] OFF_DATA_OUT   = 32'h04;
   localparam logic [31:0] OFF_DATA_IN    = 32'h08;
   localparam logic [31:0] OFF_IRQ_EN     = 32'h0C;
   localparam logic [31:0] OFF_IRQ_TYPE   = 32'h10;
   localparam logic [31:0] OFF_IRQ_POL    = 32'h14;
   localparam logic [31:0] OFF_IRQ_STATUS = 32'h18;
   localparam logic [31:0] OFF_DATA_SET   = 32'h1C;
   localparam logic [31:0] OFF_DATA_CLR   = 32'h20;

   typedef enum logic {
      IRQ_LEVEL = 1'b0,
      IRQ_EDGE  = 1'b1
   } irq_type_e;

   // Edge pins: rising/falling. Level pins: high/low.
   typedef enum logic {
      POL_LOW_FALL  = 1'b0,
      POL_HIGH_RISE = 1'b1
   } irq_pol_e;

   function automatic logic [GPIO_MAX_W-1:0] strb_mask(input logic [3:0] strb);
      logic [GPIO_MAX_W-1:0] mask;
      for (int i = 0; i < 4; i++) begin
         mask[i*8 +: 8] = {8{strb[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// One GPIO input pin: metastability synchroniser, previous-value flop and the
// interrupt qualifier (edge or level, selected polarity).
module gpio_sync_edge
   import gpio_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   input  logic irq_type,
   input  logic irq_pol,
   output logic data_in,
   output logic hit
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise;
   logic                   fall;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign data_in = sync_q[SYNC_STAGES-1];
   assign rise    = data_in & ~prev_q;
   assign fall    = ~data_in & prev_q;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the if/else can leave it unassigned and infer a latch.
   always_comb begin
      hit = 1'b0;
      if (irq_type_e'(irq_type) == IRQ_EDGE) begin
         hit = (irq_pol_e'(irq_pol) == POL_HIGH_RISE) ? rise : fall;
      end else begin
         hit = (irq_pol_e'(irq_pol) == POL_HIGH_RISE) ? data_in : ~data_in;
      end
   end

endmodule

// File: rtl/apb_gpio_irq.sv
// APB GPIO slave with per-pin direction, synchronised inputs and edge/level IRQs.
// Define GPIO_ATOMIC_SETCLR_EN to add the DATA_SET / DATA_CLR write-only registers.
module apb_gpio_irq
   import gpio_pkg::*;
#(
   parameter int GPIO_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_W      = 6
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [3:0]        PSTRB,
   input  logic [31:0]       PADDR,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   input  logic [GPIO_W-1:0] GPIO_DATA_IN,
   output logic [GPIO_W-1:0] GPIO_DATA_OUT,
   output logic [GPIO_W-1:0] GPIO_OE,
   output logic              IRQ
);

   logic [GPIO_W-1:0] dir_q;
   logic [GPIO_W-1:0] data_out_q;
   logic [GPIO_W-1:0] irq_en_q;
   logic [GPIO_W-1:0] irq_type_q;
   logic [GPIO_W-1:0] irq_pol_q;
   logic [GPIO_W-1:0] irq_status_q;
   logic              irq_q;

   logic [GPIO_W-1:0] data_in;
   logic [GPIO_W-1:0] hit;
   logic [GPIO_W-1:0] data_out_next;
   logic [GPIO_W-1:0] status_next;
   logic [GPIO_W-1:0] wmask;
   logic [GPIO_W-1:0] wdata;
   logic [GPIO_W-1:0] w1c;
   logic [31:0]       wmask_full;
   logic [31:0]       off;
   logic              access;
   logic              mapped;
   logic              err;
   logic              do_wr;
   logic              unused_bits;

   // ---------------------------------------------------------------- input path
   for (genvar i = 0; i < GPIO_W; i++) begin : g_pin
      gpio_sync_edge #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_sync_edge (
         .clk      (PCLK),
         .rst_n    (PRESETn),
         .pin      (GPIO_DATA_IN[i]),
         .irq_type (irq_type_q[i]),
         .irq_pol  (irq_pol_q[i]),
         .data_in  (data_in[i]),
         .hit      (hit[i])
      );
   end

   // ---------------------------------------------------------------- APB decode
   assign access      = PSEL & PENABLE;
   assign off         = 32'(PADDR[ADDR_W-1:0]) & ~32'h3;
   assign wmask_full  = strb_mask(PSTRB);
   assign wmask       = wmask_full[GPIO_W-1:0];
   assign wdata       = PWDATA[GPIO_W-1:0];
   assign unused_bits = ^{PADDR, PWDATA, wmask_full};

   always_comb begin
      mapped = 1'b1;
      case (off)
         OFF_DIR, OFF_DATA_OUT, OFF_DATA_IN, OFF_IRQ_EN,
         OFF_IRQ_TYPE, OFF_IRQ_POL, OFF_IRQ_STATUS: mapped = 1'b1;
`ifdef GPIO_ATOMIC_SETCLR_EN
         OFF_DATA_SET, OFF_DATA_CLR:                mapped = 1'b1;
`endif
         default:                                   mapped = 1'b0;
      endcase
   end

   assign err     = access & (~mapped | (PWRITE & (off == OFF_DATA_IN)));
   assign do_wr   = access & PWRITE & ~err;
   assign PSLVERR = err;
   assign PREADY  = 1'b1;

   always_comb begin
      PRDATA = '0;
      if (PSEL && !PWRITE) begin
         case (off)
            OFF_DIR:        PRDATA = 32'(dir_q);
            OFF_DATA_OUT:   PRDATA = 32'(data_out_q);
            OFF_DATA_IN:    PRDATA = 32'(data_in);
            OFF_IRQ_EN:     PRDATA = 32'(irq_en_q);
            OFF_IRQ_TYPE:   PRDATA = 32'(irq_type_q);
            OFF_IRQ_POL:    PRDATA = 32'(irq_pol_q);
            OFF_IRQ_STATUS: PRDATA = 32'(irq_status_q);
            default:        PRDATA = '0;
         endcase
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      data_out_next = data_out_q;
      if (do_wr && off == OFF_DATA_OUT) begin
         data_out_next = (data_out_q & ~wmask) | (wdata & wmask);
      end
`ifdef GPIO_ATOMIC_SETCLR_EN
      if (do_wr && off == OFF_DATA_SET) begin
         data_out_next = data_out_next | (wdata & wmask);
      end
      // Applied after SET so CLR wins on a shared bit.
      if (do_wr && off == OFF_DATA_CLR) begin
         data_out_next = data_out_next & ~(wdata & wmask);
      end
`endif
   end

   // Edge bits are sticky with set beating W1C; level bits follow the live condition.
   assign w1c         = (do_wr && off == OFF_IRQ_STATUS) ? (wdata & wmask) : '0;
   assign status_next = (irq_type_q & ((irq_status_q & ~w1c) | hit)) | (~irq_type_q & hit);

   // ---------------------------------------------------------------- registers
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         dir_q        <= '0;
         data_out_q   <= '0;
         irq_en_q     <= '0;
         irq_type_q   <= '0;
         irq_pol_q    <= '0;
         irq_status_q <= '0;
         irq_q        <= 1'b0;
      end else begin
         if (do_wr && off == OFF_DIR)      dir_q      <= (dir_q & ~wmask) | (wdata & wmask);
         if (do_wr && off == OFF_IRQ_EN)   irq_en_q   <= (irq_en_q & ~wmask) | (wdata & wmask);
         if (do_wr && off == OFF_IRQ_TYPE) irq_type_q <= (irq_type_q & ~wmask) | (wdata & wmask);
         if (do_wr && off == OFF_IRQ_POL)  irq_pol_q  <= (irq_pol_q & ~wmask) | (wdata & wmask);
         data_out_q   <= data_out_next;
         irq_status_q <= status_next;
         irq_q        <= |(irq_status_q & irq_en_q);
      end
   end

   assign GPIO_OE       = dir_q;
   assign GPIO_DATA_OUT = data_out_q;
   assign IRQ           = irq_q;

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Scoreboard bench for apb_gpio_irq: APB tasks queue expected responses, a
// negedge monitor pops and compares them on every access phase.
module tb_apb_gpio_irq;
   import gpio_pkg::*;

   localparam int GPIO_W = 32;
   localparam int SYNC   = 2;

   logic              PCLK;
   logic              PRESETn;
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [3:0]        PSTRB;
   logic [31:0]       PADDR;
   logic [31:0]       PWDATA;
   logic [31:0]       PRDATA;
   logic              PREADY;
   logic              PSLVERR;
   logic [GPIO_W-1:0] GPIO_DATA_IN;
   logic [GPIO_W-1:0] GPIO_DATA_OUT;
   logic [GPIO_W-1:0] GPIO_OE;
   logic              IRQ;

   apb_gpio_irq #(
      .GPIO_W      (GPIO_W),
      .SYNC_STAGES (SYNC),
      .ADDR_W      (6)
   ) dut (
      .PCLK          (PCLK),
      .PRESETn       (PRESETn),
      .PSEL          (PSEL),
      .PENABLE       (PENABLE),
      .PWRITE        (PWRITE),
      .PSTRB         (PSTRB),
      .PADDR         (PADDR),
      .PWDATA        (PWDATA),
      .PRDATA        (PRDATA),
      .PREADY        (PREADY),
      .PSLVERR       (PSLVERR),
      .GPIO_DATA_IN  (GPIO_DATA_IN),
      .GPIO_DATA_OUT (GPIO_DATA_OUT),
      .GPIO_OE       (GPIO_OE),
      .IRQ           (IRQ)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      string       name;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_dout;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   // Called just after a rising edge; returns just after the completing edge.
   task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [31:0] exp_rdata,
                      input logic exp_err, input string name);
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = wr;
      PADDR   = addr;
      PWDATA  = data;
      PSTRB   = strb;
      @(posedge PCLK);
      #1;
      PENABLE = 1'b1;
      sb_q.push_back('{exp_rdata, exp_err, name});
      @(posedge PCLK);
      #1;
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                     input logic exp_err, input string name);
      apb(1'b1, addr, data, strb, 32'h0, exp_err, name);
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp_data,
                     input logic exp_err, input string name);
      apb(1'b0, addr, 32'h0, 4'h0, exp_data, exp_err, name);
   endtask

   always @(negedge PCLK) begin
      if (PRESETn && PSEL && PENABLE) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_transfer: got addr 0x%08h expected none", PADDR);
         end else begin
            mon_e = sb_q.pop_front();
            check({mon_e.name, "_rdata"}, PRDATA, mon_e.rdata);
            check({mon_e.name, "_err"}, 32'(PSLVERR), 32'(mon_e.err));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      PRESETn      = 1'b0;
      PSEL         = 1'b0;
      PENABLE      = 1'b0;
      PWRITE       = 1'b0;
      PSTRB        = 4'h0;
      PADDR        = '0;
      PWDATA       = '0;
      GPIO_DATA_IN = '0;

      #12;
      check("rst_oe",      GPIO_OE,         32'h0);
      check("rst_dout",    GPIO_DATA_OUT,   32'h0);
      check("rst_irq",     32'(IRQ),        32'h0);
      check("rst_prdata",  PRDATA,          32'h0);
      check("rst_pslverr", 32'(PSLVERR),    32'h0);
      check("rst_pready",  32'(PREADY),     32'h1);
      PRESETn = 1'b1;
      tick(2);

      // Direction, output data, byte lanes.
      wr(OFF_DIR, 32'h0000_00F0, 4'hF, 1'b0, "wr_dir");
      wr(OFF_DATA_OUT, 32'h0000_00A5, 4'h1, 1'b0, "wr_dout");
      check("oe_f0",   GPIO_OE,       32'h0000_00F0);
      check("dout_a5", GPIO_DATA_OUT, 32'h0000_00A5);
      rd(OFF_DATA_OUT, 32'h0000_00A5, 1'b0, "rd_dout");
      rd(OFF_DIR,      32'h0000_00F0, 1'b0, "rd_dir");
      wr(OFF_DATA_OUT, 32'h1234_5678, 4'h2, 1'b0, "wr_lane1");
      rd(OFF_DATA_OUT, 32'h0000_56A5, 1'b0, "rd_lane1");
      wr(OFF_DATA_OUT, 32'hFFFF_FFFF, 4'h0, 1'b0, "wr_nostrb");
      rd(OFF_DATA_OUT, 32'h0000_56A5, 1'b0, "rd_nostrb");

      // Reset leaves every pin level-low with pins at 0: status follows that live.
      rd(OFF_IRQ_STATUS, 32'hFFFF_FFFF, 1'b0, "rd_status_lvl");
      wr(OFF_IRQ_TYPE, 32'hFFFF_FFFF, 4'hF, 1'b0, "wr_type_edge");
      tick(2);
      rd(OFF_IRQ_STATUS, 32'hFFFF_FFFF, 1'b0, "rd_status_kept");
      wr(OFF_IRQ_STATUS, 32'hFFFF_FFFF, 4'hF, 1'b0, "w1c_all");
      rd(OFF_IRQ_STATUS, 32'h0, 1'b0, "rd_status_clr");

      // Rising edge on pin0.
      wr(OFF_IRQ_EN,  32'h1, 4'hF, 1'b0, "wr_en0");
      wr(OFF_IRQ_POL, 32'h1, 4'hF, 1'b0, "wr_pol0");
      GPIO_DATA_IN[0] = 1'b1;
      tick(3);
      check("irq_rise_early", 32'(IRQ), 32'h0);
      tick(1);
      check("irq_rise", 32'(IRQ), 32'h1);
      rd(OFF_IRQ_STATUS, 32'h1, 1'b0, "rd_status_rise");
      rd(OFF_DATA_IN,    32'h1, 1'b0, "rd_data_in");
      wr(OFF_IRQ_STATUS, 32'h1, 4'hF, 1'b0, "w1c_rise");
      check("irq_hold_w1c", 32'(IRQ), 32'h1);
      tick(1);
      check("irq_clr_w1c", 32'(IRQ), 32'h0);
      GPIO_DATA_IN[0] = 1'b0;
      tick(4);
      rd(OFF_IRQ_STATUS, 32'h0, 1'b0, "rd_status_fall_ign");

      // Edge arriving on the same cycle as W1C: set wins.
      GPIO_DATA_IN[0] = 1'b1;
      tick(1);
      wr(OFF_IRQ_STATUS, 32'h1, 4'hF, 1'b0, "w1c_race");
      rd(OFF_IRQ_STATUS, 32'h1, 1'b0, "rd_status_race");
      GPIO_DATA_IN[0] = 1'b0;
      wr(OFF_IRQ_STATUS, 32'h1, 4'hF, 1'b0, "w1c_race_clr");
      tick(1);
      check("irq_race_clr", 32'(IRQ), 32'h0);

      // IRQ_EN gates IRQ only: falling edge on pin1 still recorded.
      wr(OFF_IRQ_EN, 32'h8, 4'hF, 1'b0, "wr_en3");
      GPIO_DATA_IN[1] = 1'b1;
      tick(4);
      GPIO_DATA_IN[1] = 1'b0;
      tick(4);
      rd(OFF_IRQ_STATUS, 32'h2, 1'b0, "rd_status_gated");
      check("irq_gated", 32'(IRQ), 32'h0);
      wr(OFF_IRQ_STATUS, 32'h2, 4'hF, 1'b0, "w1c_gated");

      // Level-low on pin3.
      GPIO_DATA_IN[3] = 1'b1;
      tick(4);
      wr(OFF_IRQ_TYPE, 32'hFFFF_FFF7, 4'hF, 1'b0, "wr_type_lvl3");
      tick(2);
      check("irq_lvl_idle", 32'(IRQ), 32'h0);
      GPIO_DATA_IN[3] = 1'b0;
      tick(3);
      check("irq_lvl_early", 32'(IRQ), 32'h0);
      tick(1);
      check("irq_lvl", 32'(IRQ), 32'h1);
      wr(OFF_IRQ_STATUS, 32'h8, 4'hF, 1'b0, "w1c_lvl");
      rd(OFF_IRQ_STATUS, 32'h8, 1'b0, "rd_status_lvl3");
      tick(1);
      check("irq_lvl_after_w1c", 32'(IRQ), 32'h1);
      GPIO_DATA_IN[3] = 1'b1;
      tick(3);
      check("irq_lvl_hold", 32'(IRQ), 32'h1);
      tick(1);
      check("irq_lvl_drop", 32'(IRQ), 32'h0);

      // Optional set/clear registers, or unmapped offsets without them.
`ifdef GPIO_ATOMIC_SETCLR_EN
      rd(OFF_DATA_SET, 32'h0, 1'b0, "rd_set");
      wr(OFF_DATA_SET, 32'h0000_0F00, 4'hF, 1'b0, "wr_set");
      rd(OFF_DATA_OUT, 32'h0000_5FA5, 1'b0, "rd_after_set");
      wr(OFF_DATA_CLR, 32'h0000_0005, 4'hF, 1'b0, "wr_clr");
      exp_dout = 32'h0000_5FA0;
`else
      rd(OFF_DATA_SET, 32'h0, 1'b1, "rd_set_unmapped");
      wr(OFF_DATA_CLR, 32'hFFFF_FFFF, 4'hF, 1'b1, "wr_clr_unmapped");
      exp_dout = 32'h0000_56A5;
`endif
      rd(OFF_DATA_OUT, exp_dout, 1'b0, "rd_dout_opt");

      // Slave errors leave registers untouched.
      rd(32'h0000_003C, 32'h0, 1'b1, "rd_3c");
      wr(32'h0000_003C, 32'hFFFF_FFFF, 4'hF, 1'b1, "wr_3c");
      wr(OFF_DATA_IN, 32'hFFFF_FFFF, 4'hF, 1'b1, "wr_data_in");
      rd(OFF_DIR,      32'h0000_00F0, 1'b0, "rd_dir_after_err");
      rd(OFF_DATA_OUT, exp_dout,      1'b0, "rd_dout_after_err");
      rd(OFF_IRQ_STATUS, 32'h0, 1'b0, "rd_status_boundary");

      // Raise IRQ, then hit reset in the middle of a read access.
      GPIO_DATA_IN[3] = 1'b0;
      tick(4);
      check("irq_pre_reset", 32'(IRQ), 32'h1);
      PSEL   = 1'b1;
      PWRITE = 1'b0;
      PADDR  = OFF_DIR;
      PSTRB  = 4'h0;
      @(posedge PCLK);
      #1;
      PENABLE = 1'b1;
      check("prdata_pre_reset", PRDATA, 32'h0000_00F0);
      #2;
      PRESETn = 1'b0;
      #1;
      check("areset_oe",      GPIO_OE,       32'h0);
      check("areset_dout",    GPIO_DATA_OUT, 32'h0);
      check("areset_irq",     32'(IRQ),      32'h0);
      check("areset_prdata",  PRDATA,        32'h0);
      check("areset_pslverr", 32'(PSLVERR),  32'h0);
      check("areset_pready",  32'(PREADY),   32'h1);
      @(posedge PCLK);
      #1;
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      tick(1);
      PRESETn = 1'b1;
      tick(3);
      check("irq_post_reset", 32'(IRQ), 32'h0);
      rd(OFF_DIR, 32'h0, 1'b0, "rd_dir_post_reset");

      tick(2);
      check("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_gpio_irq.md
Name: apb_gpio_irq

Overview:
Second-generation APB GPIO slave with parametrised pin count and per-pin direction control. Adds a synchronised input path, per-pin edge/level interrupt detection with sticky write-1-to-clear status, and a single combined IRQ output. Sits on the peripheral APB bus beside the other slaves; pins connect to the pad ring.

Parameters:
GPIO_W, 8, number of pins, legal 1..32
SYNC_STAGES, 2, input synchroniser depth, legal 2..4
ADDR_W, 6, PADDR bits decoded; upper bits ignored

Ports:
PCLK  in  1  APB clock
PRESETn  in  1  reset, asynchronous, active-low
PSEL  in  1  slave select
PENABLE  in  1  access phase
PWRITE  in  1  1=write, 0=read
PSTRB  in  4  byte write strobes
PADDR  in  32  byte address; [ADDR_W-1:0] decoded
PWDATA  in  32  write data
PRDATA  out  32  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  error on unmapped offset
GPIO_DATA_IN  in  GPIO_W  asynchronous pin inputs
GPIO_DATA_OUT  out  GPIO_W  output data
GPIO_OE  out  GPIO_W  output enable, 1=drive
IRQ  out  1  combined interrupt, active-high

Behaviour:
- Register map, word-aligned; bits above GPIO_W read 0, writes ignored:
  0x00 DIR (RW, 1=output); 0x04 DATA_OUT (RW); 0x08 DATA_IN (RO, synchronised); 0x0C IRQ_EN (RW); 0x10 IRQ_TYPE (RW, 1=edge, 0=level); 0x14 IRQ_POL (RW, edge: 1=rising, 0=falling; level: 1=high, 0=low); 0x18 IRQ_STATUS (R/W1C).
- Reset: all registers 0, synchroniser flops 0, GPIO_DATA_OUT=0, GPIO_OE=0, IRQ=0, PRDATA=0, PSLVERR=0, PREADY=1.
- APB: zero wait states; PREADY tied 1. Transfer completes when PSEL&PENABLE. Writes take effect on that PCLK edge.
- Each byte lane n is written only when PSTRB[n]=1. PSTRB=0 on a write is a legal no-op.
- PRDATA is combinational: selected register when PSEL&!PWRITE, else 0.
- PSLVERR=1 during the access phase for offsets >0x18 (>0x20 with the option), or for a write to 0x08. Registers are unchanged.
- GPIO_OE=DIR and GPIO_DATA_OUT=DATA_OUT. Pins remain readable via DATA_IN whatever DIR is.
- Input path: SYNC_STAGES flops per pin. DATA_IN reflects a pin change SYNC_STAGES cycles after the sampling edge. One extra flop holds the previous synchronised value for edge detection.
- Edge pin: STATUS bit sets on the cycle after the qualifying transition appears in DATA_IN. It stays set until a W1C write.
- Level pin: STATUS bit = registered live condition. W1C has no effect.
- Changing IRQ_TYPE or IRQ_POL does not clear STATUS; software must W1C.
- Simultaneous W1C and new edge on the same bit: set wins.
- IRQ is registered: IRQ = |(IRQ_STATUS & IRQ_EN), one cycle after STATUS. IRQ_EN gates IRQ only; STATUS still records events.
- Reset asserted mid-transfer: all state clears immediately. The in-flight transfer is lost.

Optional Feature:
GPIO_ATOMIC_SETCLR_EN
- Defined: adds 0x1C DATA_SET and 0x20 DATA_CLR (WO, read 0).
  - Writing 1s sets or clears the matching DATA_OUT bits.
  - If SET and CLR would hit the same bit in one cycle, CLR wins.
  - Ordinary DATA_OUT writes are unaffected.
- Undefined: offsets 0x1C and 0x20 are unmapped and raise PSLVERR.

Decomposition:
- Package gpio_pkg: register offset localparams, IRQ_TYPE/IRQ_POL encodings, max-width constant 32.
- Sub-module gpio_sync_edge: per-pin synchroniser, delay flop, and rise/fall/level-qualified event output, instantiated by generate over GPIO_W.
- Top holds the APB decode, register file and IRQ reduction.

Test Plan:
1. Write DIR=0xF0, then DATA_OUT=0xA5 with PSTRB=0001 -> GPIO_OE=0xF0, GPIO_DATA_OUT=0xA5; readback returns 0xA5 and 0xF0.
2. Write DATA_OUT=0x12345678 with PSTRB=0010, GPIO_W=32 -> only bits[15:8] change to 0x56; others hold.
3. IRQ_EN=0x01, TYPE=0x01, POL=0x01; pin0 goes 0->1 -> STATUS[0]=1 at sync+1 cycles, IRQ=1 one cycle later. W1C 0x01 -> IRQ=0.
4. Level-low on pin3 (TYPE=0, POL=0, EN=0x08); drive pin3=0 -> IRQ stays high through a W1C. Pin3=1 -> IRQ drops after sync+2 cycles.
5. Rising edge on pin0 in the same cycle as a W1C of bit0 -> STATUS[0] remains 1.
6. Read offset 0x3C, then write 0x08 -> PSLVERR=1, PRDATA=0, no register changes. Assert PRESETn=0 mid-access -> all outputs reset asynchronously.
